ps2_key_tracker: RTL and testbench
==================================

Name: ps2_key_tracker

Overview:
- Consumes the byte stream from the PS/2 serial receiver and decodes scan-code set 2 make/break sequences, including E0-extended keys.
- Maintains the 512-bit key_down vector, indexed by the 9-bit code {extended, byte}, for the game-control mapping logic.
- Also provides last_change and a one-cycle been_ready strobe per key event.
- Sits between the PS/2 byte receiver and the player/menu key-mapping stage.

Parameters:
- TIMEOUT_CYCLES, 2_000_000, maximum clk cycles allowed between a prefix byte (E0/F0) and its follow-up byte; 20 ms at 100 MHz.
- REPEAT_PULSE, 1, 1 = a typematic repeat make of a key already held still pulses been_ready; 0 = repeats are silent.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- rx_data  input  8  byte from the PS/2 receiver
- rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle
- key_down  output  512  bit k = 1 while key code k is held
- last_change  output  9  {extended, code} of the most recent make/break event
- been_ready  output  1  one-cycle pulse after a key event updates the outputs
- key_release  output  1  valid with been_ready; 1 = break event, 0 = make event
- seq_error  output  1  one-cycle pulse on timeout or on an illegal/overrun byte

Behaviour:
- Clock and reset:
  - One clock (clk); rst is synchronous and active-high.
  - While rst is high, all outputs are 0 and the FSM is in IDLE.
  - Asserting rst mid-sequence discards the partial sequence and clears all key_down bits.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen). Transitions happen only on rx_valid.
  - IDLE:
    - E0 -> EXT; F0 -> BRK.
    - AA (BAT ok): clear all of key_down, stay in IDLE, no been_ready.
    - 00, FF, FC (overrun/error): clear key_down, pulse seq_error, stay in IDLE.
    - Any other byte b: make event for code {0,b}.
  - EXT:
    - F0 -> EXT_BRK.
    - 12 or 59 (fake shifts): ignore -> IDLE.
    - Any other byte b: make event for {1,b} -> IDLE.
  - BRK: byte b is a break event for {0,b} -> IDLE.
  - EXT_BRK:
    - 12 or 59: ignore -> IDLE.
    - Any other byte b: break event for {1,b} -> IDLE.
  - An E0 or F0 received in BRK or EXT_BRK is illegal: pulse seq_error -> IDLE.
  - The E1 (Pause key) prefix is dropped: E1 in IDLE enters no state. The follow-on bytes of the Pause sequence (14 77 E1 F0 14 F0 77) decode as ordinary keys, which the mapping stage ignores.
- Event timing:
  - Final byte accepted on cycle N -> key_down bit set (make) or cleared (break) on cycle N+1.
  - last_change, key_release and been_ready are also valid on cycle N+1.
  - been_ready is high for exactly one cycle.
- Repeats and redundant breaks:
  - Make for a code whose bit is already 1: key_down is unchanged, last_change is updated, and been_ready pulses only when REPEAT_PULSE = 1.
  - Break for a code whose bit is already 0: been_ready still pulses, and no bits change.
- Timeout:
  - A counter runs in any non-IDLE state and reloads on every rx_valid.
  - When it reaches TIMEOUT_CYCLES-1, the FSM returns to IDLE and seq_error pulses.
  - If rx_valid arrives in the same cycle as the timeout, the timeout takes priority, and that byte is decoded from IDLE.
- Width rule: the key index is always 9 bits; all other bits of key_down are unaffected by an event.
- Only one key_down bit changes per event; there are never simultaneous updates.

Decomposition:
- Shared package ps2_pkg holds:
  - Byte constants: PS2_EXT = 8'hE0, PS2_BRK = 8'hF0, PS2_BAT = 8'hAA, PS2_PAUSE = 8'hE1, PS2_FAKE_LSHIFT = 8'h12, PS2_FAKE_PRTSC = 8'h59, and the error bytes.
  - The FSM state typedef.
  - The 9-bit key-code typedef, shared with the key-mapping stage.
- One sub-module, ps2_seq_timer: the reloadable timeout counter with a one-cycle expire output.
- Sequence decoding and the key_down register file stay in the top.

Test Plan:
- Send 1B -> next cycle key_down[0x01B] = 1, last_change = 0x01B, key_release = 0, and been_ready is high for exactly 1 cycle. Then send F0 1B -> key_down[0x01B] = 0, key_release = 1.
- Send E0 75 (extended Up) -> key_down[0x175] = 1. Then send E0 F0 75 -> key_down[0x175] = 0. key_down[0x075] stays 0 throughout.
- With 1B held, send 29 -> both key_down[0x01B] and key_down[0x029] = 1. Repeat 29 three times -> key_down unchanged, been_ready pulses 3 times (REPEAT_PULSE = 1) or 0 times (REPEAT_PULSE = 0).
- Send E0 12 E0 7C, then E0 F0 7C E0 F0 12 (PrtSc) -> only key_down[0x17C] toggles; key_down[0x112] and key_down[0x012] stay 0.
- Send F0, then idle TIMEOUT_CYCLES (set to 50 for the test) -> seq_error pulses. Then send 23 -> it is treated as a make, and key_down[0x023] = 1.
- Hold 3 keys, then send AA -> all key_down = 0 with no been_ready pulse. Separately, assert rst after E0 F0 -> all outputs 0, and a following 5A yields a make for 0x05A.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 scan-code set 2 constants, FSM state and key-code types
package ps2_pkg;

  localparam logic [7:0] PS2_EXT         = 8'hE0;
  localparam logic [7:0] PS2_BRK         = 8'hF0;
  localparam logic [7:0] PS2_BAT         = 8'hAA;
  localparam logic [7:0] PS2_PAUSE       = 8'hE1;
  localparam logic [7:0] PS2_FAKE_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_FAKE_PRTSC  = 8'h59;
  localparam logic [7:0] PS2_ERR_00      = 8'h00;
  localparam logic [7:0] PS2_ERR_FF      = 8'hFF;
  localparam logic [7:0] PS2_ERR_FC      = 8'hFC;

  typedef logic [1:0] ps2_state_t;
  localparam ps2_state_t ST_IDLE    = 2'd0;
  localparam ps2_state_t ST_EXT     = 2'd1;
  localparam ps2_state_t ST_BRK     = 2'd2;
  localparam ps2_state_t ST_EXT_BRK = 2'd3;

  // {extended, scan byte}; also consumed by the key-mapping stage
  typedef logic [8:0] key_code_t;

  function automatic logic is_fake_shift(input logic [7:0] b);
    return (b == PS2_FAKE_LSHIFT) || (b == PS2_FAKE_PRTSC);
  endfunction

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PS2_EXT) || (b == PS2_BRK);
  endfunction

endpackage

// File: rtl/ps2_seq_timer.sv
// rtl/ps2_seq_timer.sv - reloadable inter-byte timeout counter with one-cycle expire
module ps2_seq_timer #(
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic reload,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign expire = run && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || !run || reload || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - scan-code set 2 make/break decoder and 512-bit key_down tracker
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter bit REPEAT_PULSE   = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic [511:0] key_down,
  output logic [8:0]   last_change,
  output logic         been_ready,
  output logic         key_release,
  output logic         seq_error
);

  ps2_state_t state;
  ps2_state_t cur_state;
  ps2_state_t next_state;
  logic       expire;
  logic       ev;
  logic       ev_brk;
  key_code_t  ev_code;
  logic       clr_all;
  logic       err;

  ps2_seq_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .run    (state != ST_IDLE),
    .reload (rx_valid),
    .expire (expire)
  );

  // A timeout in the same cycle as a byte wins: the byte is decoded from IDLE.
  assign cur_state = expire ? ST_IDLE : state;

  always_comb begin
    next_state = cur_state;
    ev         = 1'b0;
    ev_brk     = 1'b0;
    ev_code    = {1'b0, rx_data};
    clr_all    = 1'b0;
    err        = expire;
    if (rx_valid) begin
      case (cur_state)
        ST_IDLE: begin
          case (rx_data)
            PS2_EXT:   next_state = ST_EXT;
            PS2_BRK:   next_state = ST_BRK;
            PS2_BAT:   clr_all = 1'b1;
            PS2_PAUSE: ;
            PS2_ERR_00, PS2_ERR_FF, PS2_ERR_FC: begin
              clr_all = 1'b1;
              err     = 1'b1;
            end
            default:   ev = 1'b1;
          endcase
        end
        ST_EXT: begin
          if (rx_data == PS2_BRK) begin
            next_state = ST_EXT_BRK;
          end else begin
            next_state = ST_IDLE;
            ev         = !is_fake_shift(rx_data);
            ev_code    = {1'b1, rx_data};
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          next_state = ST_IDLE;
          ev_code    = {cur_state == ST_EXT_BRK, rx_data};
          if (is_prefix(rx_data)) begin
            err = 1'b1;
          end else if (!(cur_state == ST_EXT_BRK && is_fake_shift(rx_data))) begin
            ev     = 1'b1;
            ev_brk = 1'b1;
          end
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      key_down    <= '0;
      last_change <= '0;
      been_ready  <= 1'b0;
      key_release <= 1'b0;
      seq_error   <= 1'b0;
    end else begin
      state      <= next_state;
      seq_error  <= err;
      been_ready <= 1'b0;
      if (clr_all) begin
        key_down <= '0;
      end
      if (ev) begin
        last_change       <= ev_code;
        key_release       <= ev_brk;
        key_down[ev_code] <= !ev_brk;
        been_ready        <= ev_brk || !key_down[ev_code] || REPEAT_PULSE;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb/tb_ps2_key_tracker.sv - randomized self-checking bench for ps2_key_tracker
module tb_ps2_key_tracker;

  localparam int T   = 50;
  localparam bit REP = 1'b1;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic [511:0] key_down;
  logic [8:0]   last_change;
  logic         been_ready;
  logic         key_release;
  logic         seq_error;

  ps2_key_tracker #(
    .TIMEOUT_CYCLES(T),
    .REPEAT_PULSE  (REP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .key_down   (key_down),
    .last_change(last_change),
    .been_ready (been_ready),
    .key_release(key_release),
    .seq_error  (seq_error)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference: held-key set plus the prefixes still waiting for a follow-up byte
  bit [511:0] m_kd;
  bit [8:0]   m_last;
  bit         m_rel, m_rdy, m_err;
  bit         p_ext, p_brk;
  int         gap;

  logic [7:0] pool [0:18] = '{8'h1B, 8'h29, 8'h75, 8'h7C, 8'h12, 8'h59, 8'h23, 8'h5A,
                              8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'hAA, 8'hE1, 8'h00, 8'hFF,
                              8'hFC, 8'h14, 8'h77};

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_step(input bit r, input bit v, input logic [7:0] b);
    bit [8:0] c;
    m_rdy = 1'b0;
    m_err = 1'b0;
    if (gap < 1_000_000) gap++;
    if (r) begin
      m_kd = '0; m_last = '0; m_rel = 1'b0; p_ext = 1'b0; p_brk = 1'b0; gap = 0;
      return;
    end
    if ((p_ext || p_brk) && gap == T) begin
      m_err = 1'b1; p_ext = 1'b0; p_brk = 1'b0;
    end
    if (!v) return;
    gap = 0;
    if (!p_ext && !p_brk) begin
      if (b == 8'hE0) p_ext = 1'b1;
      else if (b == 8'hF0) p_brk = 1'b1;
      else if (b == 8'hAA) m_kd = '0;
      else if (b == 8'h00 || b == 8'hFF || b == 8'hFC) begin m_kd = '0; m_err = 1'b1; end
      else if (b != 8'hE1) begin
        c = {1'b0, b};
        m_rdy = !m_kd[c] || REP; m_kd[c] = 1'b1; m_last = c; m_rel = 1'b0;
      end
    end else if (p_brk) begin
      if (b == 8'hE0 || b == 8'hF0) m_err = 1'b1;
      else if (!(p_ext && (b == 8'h12 || b == 8'h59))) begin
        c = {p_ext, b};
        m_rdy = 1'b1; m_kd[c] = 1'b0; m_last = c; m_rel = 1'b1;
      end
      p_ext = 1'b0; p_brk = 1'b0;
    end else begin
      if (b == 8'hF0) p_brk = 1'b1;
      else begin
        if (!(b == 8'h12 || b == 8'h59)) begin
          c = {1'b1, b};
          m_rdy = !m_kd[c] || REP; m_kd[c] = 1'b1; m_last = c; m_rel = 1'b0;
        end
        p_ext = 1'b0;
      end
    end
  endtask

  task automatic tick(input bit r, input bit v, input logic [7:0] b);
    rst = r; rx_valid = v; rx_data = b;
    @(negedge clk);
    model_step(r, v, b);
    check_eq("key_down",    key_down,          m_kd);
    check_eq("last_change", 512'(last_change), 512'(m_last));
    check_eq("been_ready",  512'(been_ready),  512'(m_rdy));
    check_eq("key_release", 512'(key_release), 512'(m_rel));
    check_eq("seq_error",   512'(seq_error),   512'(m_err));
    rst = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int idle);
    tick(1'b0, 1'b1, b);
    repeat (idle) tick(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    int idle, sel;
    logic [7:0] b;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    gap = 0;
    @(negedge clk);
    repeat (3) tick(1'b1, 1'b0, 8'h00);
    check_eq("reset_key_down", key_down, '0);

    send(8'h1B, 0);
    check_eq("make_1b_bit", 512'(key_down[9'h01B]), 512'(1'b1));
    check_eq("make_1b_ready", 512'(been_ready), 512'(1'b1));
    tick(1'b0, 1'b0, 8'h00);
    check_eq("ready_one_cycle", 512'(been_ready), 512'(1'b0));
    send(8'hF0, 0); send(8'h1B, 1);
    send(8'hE0, 0); send(8'h75, 1);
    check_eq("ext_up_set", 512'(key_down[9'h175]), 512'(1'b1));
    check_eq("plain_75_clear", 512'(key_down[9'h075]), 512'(1'b0));
    send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 1);
    send(8'h1B, 0); send(8'h29, 0);
    repeat (3) send(8'h29, 1);
    send(8'hE0, 0); send(8'h12, 0); send(8'hE0, 0); send(8'h7C, 1);
    check_eq("prtsc_set", 512'(key_down[9'h17C]), 512'(1'b1));
    check_eq("fake_shift_clear", 512'({key_down[9'h112], key_down[9'h012]}), 512'(2'b00));
    send(8'hE0, 0); send(8'hF0, 0); send(8'h7C, 0);
    send(8'hE0, 0); send(8'hF0, 0); send(8'h12, 1);
    send(8'hF0, T);
    check_eq("timeout_err", 512'(seq_error), 512'(1'b1));
    send(8'h23, 1);
    check_eq("post_timeout_make", 512'(key_down[9'h023]), 512'(1'b1));
    send(8'hAA, 1);
    check_eq("bat_clear", key_down, '0);
    send(8'hE0, 0); send(8'hF0, 0);
    tick(1'b1, 1'b0, 8'h00);
    send(8'h5A, 1);
    check_eq("post_rst_make", 512'(last_change), 512'(9'h05A));

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) tick(1'b1, 1'b0, 8'h00);
      sel = $urandom_range(0, 9);
      b = (sel == 0) ? 8'($urandom) : pool[$urandom_range(0, 18)];
      sel = $urandom_range(0, 19);
      if (sel < 14) idle = $urandom_range(0, 2);
      else if (sel < 18) idle = T - 3 + $urandom_range(0, 3);
      else idle = $urandom_range(0, 5);
      send(b, idle);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
